// File: rtl/wide_add_sequencer.sv
// wide_add_sequencer: multi-precision adder. One 32-bit carry bypass adder
// is stepped across WORDS words, least significant word first. The carry is
// held in a register between words.
// Optional macro WIDE_ADD_SUB_EN adds a sub_i input that selects A-B.
module wide_add_sequencer #(
    parameter int WORDS = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start_i,
    input  logic [32*WORDS-1:0]   a_i,
    input  logic [32*WORDS-1:0]   b_i,
    input  logic                  cin_i,
`ifdef WIDE_ADD_SUB_EN
    input  logic                  sub_i,
`endif
    output logic                  ready_o,
    output logic                  busy_o,
    output logic                  done_o,
    output logic [32*WORDS-1:0]   sum_o,
    output logic                  cout_o,
    output logic                  overflow_o
);

    localparam int W     = 32 * WORDS;
    localparam int IDX_W = $clog2(WORDS);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t                 state;
    logic [IDX_W-1:0]       idx;
    logic                   carry_r;
    logic [W-1:0]           op_a;
    logic [W-1:0]           op_b;

    logic [31:0]            word_a;
    logic [31:0]            word_b;
    logic [31:0]            add_s;
    logic                   add_co;

    // 32-bit carry bypass adder: eight 4-bit ripple blocks. A block whose
    // bits all propagate passes its incoming carry straight through; the
    // value returned in bit 32 is the carry at the end of the bypass chain.
    function automatic logic [32:0] cba_add(input logic [31:0] a,
                                            input logic [31:0] b,
                                            input logic        ci);
        logic [31:0] p;
        logic [31:0] g;
        logic [31:0] s;
        logic        c_blk;
        logic        c_rip;
        p     = a ^ b;
        g     = a & b;
        s     = '0;
        c_blk = ci;
        for (int blk = 0; blk < 8; blk++) begin
            c_rip = c_blk;
            for (int k = 0; k < 4; k++) begin
                s[blk*4+k] = p[blk*4+k] ^ c_rip;
                c_rip      = g[blk*4+k] | (p[blk*4+k] & c_rip);
            end
            c_blk = (&p[blk*4 +: 4]) ? c_blk : c_rip;
        end
        return {c_blk, s};
    endfunction

    // Signed overflow: both operands share a sign and the result sign differs.
    function automatic logic ovf_detect(input logic a_msb,
                                        input logic b_msb,
                                        input logic s_msb);
        return (a_msb == b_msb) && (s_msb != a_msb);
    endfunction

    // Feed the current word of each operand and the running carry to the adder
    always_comb begin
        word_a          = op_a[idx*32 +: 32];
        word_b          = op_b[idx*32 +: 32];
        {add_co, add_s} = cba_add(word_a, word_b, carry_r);
    end

    // Sequencer FSM with registered handshake and result outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            ready_o    <= 1'b1;
            busy_o     <= 1'b0;
            done_o     <= 1'b0;
            sum_o      <= '0;
            cout_o     <= 1'b0;
            overflow_o <= 1'b0;
            idx        <= '0;
            carry_r    <= 1'b0;
            op_a       <= '0;
            op_b       <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start_i) begin
                        op_a       <= a_i;
`ifdef WIDE_ADD_SUB_EN
                        op_b       <= sub_i ? ~b_i : b_i;
                        carry_r    <= sub_i ? 1'b1 : cin_i;
`else
                        op_b       <= b_i;
                        carry_r    <= cin_i;
`endif
                        idx        <= '0;
                        sum_o      <= '0;
                        cout_o     <= 1'b0;
                        overflow_o <= 1'b0;
                        ready_o    <= 1'b0;
                        busy_o     <= 1'b1;
                        state      <= RUN;
                    end
                end
                RUN: begin
                    sum_o[idx*32 +: 32] <= add_s;
                    carry_r             <= add_co;
                    if (idx == IDX_W'(WORDS - 1)) begin
                        idx        <= '0;
                        cout_o     <= add_co;
                        overflow_o <= ovf_detect(op_a[W-1], op_b[W-1], add_s[31]);
                        busy_o     <= 1'b0;
                        done_o     <= 1'b1;
                        state      <= DONE;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                DONE: begin
                    done_o  <= 1'b0;
                    ready_o <= 1'b1;
                    state   <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_wide_add_sequencer.sv
// Bench for wide_add_sequencer (WORDS=4). It uses a vector table and a
// scoreboard queue, plus hand-written sequences for start held high and for
// a reset issued mid-operation. Define WIDE_ADD_SUB_EN to add the subtract
// vectors.
module tb_wide_add_sequencer;

    localparam int WORDS = 4;
    localparam int W     = 32 * WORDS;

    logic           clk = 1'b0;
    logic           rst;
    logic           start_i;
    logic [W-1:0]   a_i;
    logic [W-1:0]   b_i;
    logic           cin_i;
`ifdef WIDE_ADD_SUB_EN
    logic           sub_i;
`endif
    logic           ready_o;
    logic           busy_o;
    logic           done_o;
    logic [W-1:0]   sum_o;
    logic           cout_o;
    logic           overflow_o;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         cin;
        logic         sub;
        logic [W-1:0] sum;
        logic         cout;
        logic         ovf;
    } vec_t;

    vec_t tbl[$];
    vec_t sb[$];
    int   checks = 0;
    int   errors = 0;

    wide_add_sequencer #(.WORDS(WORDS)) dut (
        .clk        (clk),
        .rst        (rst),
        .start_i    (start_i),
        .a_i        (a_i),
        .b_i        (b_i),
        .cin_i      (cin_i),
`ifdef WIDE_ADD_SUB_EN
        .sub_i      (sub_i),
`endif
        .ready_o    (ready_o),
        .busy_o     (busy_o),
        .done_o     (done_o),
        .sum_o      (sum_o),
        .cout_o     (cout_o),
        .overflow_o (overflow_o)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog act=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%h exp=%h", name, act, exp);
        end
    endtask

    // Reference: plain wide addition, with subtraction as A + ~B + 1
    function automatic vec_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                   input logic cin, input logic sub);
        vec_t       v;
        logic [W:0] r;
        logic [W-1:0] bb;
        logic       c;
        bb = sub ? ~b : b;
        c  = sub ? 1'b1 : cin;
        r  = {1'b0, a} + {1'b0, bb} + {{W{1'b0}}, c};
        v.a = a; v.b = b; v.cin = cin; v.sub = sub;
        v.sum  = r[W-1:0];
        v.cout = r[W];
        v.ovf  = (a[W-1] == bb[W-1]) && (r[W-1] != a[W-1]);
        return v;
    endfunction

    function automatic vec_t mk(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin,
                                input logic sub, input logic [W-1:0] s, input logic co,
                                input logic ov);
        vec_t v;
        v.a = a; v.b = b; v.cin = cin; v.sub = sub; v.sum = s; v.cout = co; v.ovf = ov;
        return v;
    endfunction

    task automatic wait_ready(input string name);
        int n = 0;
        while (!ready_o && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!ready_o) chk({name, "_ready_timeout"}, {{(W-1){1'b0}}, ready_o}, 1);
    endtask

    // Called at the negedge after the accept edge; waits for done_o, then checks latency and result
    task automatic wait_done(input string name);
        int   edges = 0;
        vec_t e;
        while (!done_o && edges < 20) begin
            @(posedge clk);
            edges++;
            @(negedge clk);
        end
        if (!done_o) begin
            chk({name, "_done_timeout"}, 0, 1);
        end else begin
            chk({name, "_latency"}, edges, WORDS);
            if (sb.size() == 0) begin
                chk({name, "_sb_empty"}, 0, 1);
            end else begin
                e = sb.pop_front();
                chk({name, "_sum"},  sum_o, e.sum);
                chk({name, "_cout"}, cout_o, e.cout);
                chk({name, "_ovf"},  overflow_o, e.ovf);
            end
            @(negedge clk);
            chk({name, "_done_pulse"}, done_o, 0);
            chk({name, "_ready_after"}, ready_o, 1);
            if (e.sum !== 'x) chk({name, "_sum_held"}, sum_o, e.sum);
        end
    endtask

    task automatic do_op(input vec_t v, input string name);
        wait_ready(name);
        start_i = 1'b1;
        a_i = v.a; b_i = v.b; cin_i = v.cin;
`ifdef WIDE_ADD_SUB_EN
        sub_i = v.sub;
`endif
        @(posedge clk);
        sb.push_back(v);
        @(negedge clk);
        start_i = 1'b0;
        chk({name, "_busy"}, busy_o, 1);
        chk({name, "_not_ready"}, ready_o, 0);
        // operands changing after acceptance must not matter
        a_i = {$urandom(), $urandom(), $urandom(), $urandom()};
        b_i = {$urandom(), $urandom(), $urandom(), $urandom()};
        cin_i = ~v.cin;
        wait_done(name);
    endtask

    initial begin
        vec_t e;
        int   done_cnt;
        int   seen;
        bit   acc2;
        logic [W-1:0] ones;
        logic [W-1:0] one;

        ones = '1;
        one  = 1;
        tbl.push_back(mk(one, ones, 1'b0, 1'b0, '0, 1'b1, 1'b0));
        tbl.push_back(mk({32'h0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF}, one, 1'b0, 1'b0,
                         {32'h1, 32'h0, 32'h0, 32'h0}, 1'b0, 1'b0));
        tbl.push_back(mk({32'h7FFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF}, '0, 1'b1, 1'b0,
                         {32'h80000000, 32'h0, 32'h0, 32'h0}, 1'b0, 1'b1));
        tbl.push_back(mk(ones, ones, 1'b1, 1'b0, ones, 1'b1, 1'b0));
        tbl.push_back(mk({32'h80000000, 96'h0}, {32'h80000000, 96'h0}, 1'b0, 1'b0,
                         '0, 1'b1, 1'b1));
        for (int i = 0; i < 4; i++)
            tbl.push_back(model({$urandom(), $urandom(), $urandom(), $urandom()},
                                {$urandom(), $urandom(), $urandom(), $urandom()},
                                1'($urandom_range(1)), 1'b0));
`ifdef WIDE_ADD_SUB_EN
        tbl.push_back(mk('0, one, 1'b0, 1'b1, ones, 1'b0, 1'b0));
        tbl.push_back(mk(128'd3, 128'd3, 1'b0, 1'b1, '0, 1'b1, 1'b0));
`endif

        rst = 1'b1; start_i = 1'b0; a_i = '0; b_i = '0; cin_i = 1'b0;
`ifdef WIDE_ADD_SUB_EN
        sub_i = 1'b0;
`endif
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_ready", ready_o, 1);
        chk("rst_busy",  busy_o, 0);
        chk("rst_done",  done_o, 0);
        chk("rst_sum",   sum_o, 0);
        chk("rst_cout",  cout_o, 0);
        chk("rst_ovf",   overflow_o, 0);
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < tbl.size(); i++)
            do_op(tbl[i], $sformatf("vec%0d", i));

        // start held high across RUN and DONE: one result, then a second accept
        wait_ready("hold");
        start_i = 1'b1; a_i = 5; b_i = 7; cin_i = 1'b0;
`ifdef WIDE_ADD_SUB_EN
        sub_i = 1'b0;
`endif
        @(posedge clk);
        sb.push_back(model(5, 7, 1'b0, 1'b0));
        @(negedge clk);
        a_i = 9; b_i = 9;
        done_cnt = 0;
        acc2 = 1'b0;
        for (int c = 0; c < 30 && !acc2; c++) begin
            if (done_o) begin
                done_cnt++;
                if (sb.size() > 0) begin
                    e = sb.pop_front();
                    chk("hold_first_sum", sum_o, e.sum);
                end
            end
            if (ready_o) begin
                @(posedge clk);
                sb.push_back(model(9, 9, 1'b0, 1'b0));
                acc2 = 1'b1;
                @(negedge clk);
                start_i = 1'b0;
            end else begin
                @(negedge clk);
            end
        end
        chk("hold_second_accept", acc2, 1);
        chk("hold_single_done", done_cnt, 1);
        if (acc2) wait_done("hold_second");

        // reset while the word index is 2
        wait_ready("abort");
        start_i = 1'b1; a_i = ones; b_i = ones; cin_i = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start_i = 1'b0;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk("abort_ready", ready_o, 1);
        chk("abort_busy",  busy_o, 0);
        chk("abort_sum",   sum_o, 0);
        chk("abort_cout",  cout_o, 0);
        seen = 0;
        for (int c = 0; c < 10; c++) begin
            if (done_o) seen++;
            @(negedge clk);
        end
        chk("abort_no_done", seen, 0);

        do_op(tbl[1], "after_abort");
        chk("sb_drained", sb.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
